// File: rtl/zion_basic_circuit_lib_skid_stage.sv
// Two-entry valid/ready skid stage: registered data, valid and ready, with a
// synchronous flush that returns the stage to the post-reset state.
module zion_basic_circuit_lib_skid_stage #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iVld,
  output logic             oRdy,
  input  logic [WIDTH-1:0] iDat,
  output logic             oVld,
  input  logic             iRdy,
  output logic [WIDTH-1:0] oDat,
  output logic [1:0]       oCnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = iVld & oRdy;
  assign out_xfer = oVld & iRdy;

  always_ff @(posedge clk) begin
    if (rst || iClr) begin
      state_q <= EMPTY;
      main_q  <= INI_DATA;
      skid_q  <= INI_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_q <= ONE;
            main_q  <= iDat;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= iDat;
          end else if (in_xfer) begin
            // Downstream stalled: park the new beat behind the head.
            state_q <= FULL;
            skid_q  <= iDat;
          end else if (out_xfer) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_q <= ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Handshake outputs come from state flops only, so iRdy never reaches oRdy.
  always_comb begin
    oVld = 1'b0;
    oRdy = 1'b1;
    oCnt = 2'd0;
    unique case (state_q)
      EMPTY: begin oVld = 1'b0; oRdy = 1'b1; oCnt = 2'd0; end
      ONE:   begin oVld = 1'b1; oRdy = 1'b1; oCnt = 2'd1; end
      FULL:  begin oVld = 1'b1; oRdy = 1'b0; oCnt = 2'd2; end
      default: begin oVld = 1'b0; oRdy = 1'b1; oCnt = 2'd0; end
    endcase
  end

  assign oDat = main_q;

endmodule
